// File: rtl/alu_result_deserializer.sv
// alu_result_deserializer: one-hot lane beats to parallel result word; ALU_RESULT_DESER_PARITY_EN adds a parity beat and res_par_err
module alu_result_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       sel,
  input  logic [5:0]       Fi,
  input  logic             fi_valid,
  output logic             fi_ready,
  output logic [WIDTH-1:0] res_word,
  output logic [2:0]       res_sel,
  output logic             res_lane_err,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef ALU_RESULT_DESER_PARITY_EN
  output logic             res_par_err,
`endif
  output logic             sel_err
);
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] COLLECT = 2'b01;
  localparam logic [1:0] HOLD    = 2'b10;
  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_RESULT_DESER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [2:0]       sel_q, sel_d;
  logic             lerr_q, lerr_d;
  logic             sel_err_q, sel_err_d;
  logic [2:0]       lane;
  logic             bit_in, viol, accept, last_beat;
`ifdef ALU_RESULT_DESER_PARITY_EN
  logic             par_q, par_d;
`endif
  always_comb begin
    lane      = sel == 3'd6 ? 3'd4 : sel == 3'd7 ? 3'd5 : {1'b0, sel[1:0]};
    bit_in    = Fi[lane];
    viol      = |(Fi & ~(6'b1 << lane));
    fi_ready  = state_q != HOLD;
    accept    = fi_valid & fi_ready;
    last_beat = cnt_q == CW'(LAST);
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    sel_d     = sel_q;
    lerr_d    = lerr_q;
    sel_err_d = 1'b0;
`ifdef ALU_RESULT_DESER_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q == IDLE && accept) begin
      state_d = COLLECT;
      cnt_d   = CW'(1);
      word_d  = WIDTH'(bit_in);
      sel_d   = sel;
      lerr_d  = viol;
`ifdef ALU_RESULT_DESER_PARITY_EN
      par_d   = 1'b0;
`endif
    end else if (state_q == COLLECT && accept) begin
      if (sel != sel_q) begin
        state_d   = IDLE;
        cnt_d     = '0;
        sel_err_d = 1'b1;
      end else begin
        // at the parity position the shift falls off the word, so only par_q takes the bit
        word_d  = word_q | (WIDTH'(bit_in) << cnt_q);
        lerr_d  = lerr_q | viol;
        state_d = last_beat ? HOLD : COLLECT;
        cnt_d   = last_beat ? cnt_q : cnt_q + CW'(1);
`ifdef ALU_RESULT_DESER_PARITY_EN
        par_d   = last_beat ? bit_in : par_q;
`endif
      end
    end else if (state_q == HOLD && res_ready) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      sel_q     <= '0;
      lerr_q    <= 1'b0;
      sel_err_q <= 1'b0;
`ifdef ALU_RESULT_DESER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      sel_q     <= sel_d;
      lerr_q    <= lerr_d;
      sel_err_q <= sel_err_d;
`ifdef ALU_RESULT_DESER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end
  assign res_word     = word_q;
  assign res_sel      = sel_q;
  assign res_lane_err = lerr_q;
  assign res_valid    = state_q == HOLD;
  assign sel_err      = sel_err_q;
`ifdef ALU_RESULT_DESER_PARITY_EN
  assign res_par_err  = ^word_q ^ par_q;
`endif
endmodule

// File: tb/tb_alu_result_deserializer.sv
// tb_alu_result_deserializer: directed self-checking bench for alu_result_deserializer
module tb_alu_result_deserializer;
  localparam int W = 8;
`ifdef ALU_RESULT_DESER_PARITY_EN
  localparam int NB = W + 1;
  logic res_par_err;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] sel = '0;
  logic [5:0] Fi = '0;
  logic fi_valid = 1'b0;
  logic res_ready = 1'b1;
  logic fi_ready, res_lane_err, res_valid, sel_err;
  logic [W-1:0] res_word;
  logic [2:0] res_sel;
  int checks = 0;
  int fails = 0;

  alu_result_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .Fi(Fi), .fi_valid(fi_valid),
    .fi_ready(fi_ready), .res_word(res_word), .res_sel(res_sel),
    .res_lane_err(res_lane_err), .res_valid(res_valid), .res_ready(res_ready),
`ifdef ALU_RESULT_DESER_PARITY_EN
    .res_par_err(res_par_err),
`endif
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] lane_of(input logic [2:0] s);
    case (s)
      3'd0: return 3'd0;
      3'd1: return 3'd1;
      3'd2: return 3'd2;
      3'd3: return 3'd3;
      3'd4: return 3'd0;
      3'd5: return 3'd1;
      3'd6: return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [W:0] wd(input logic [W-1:0] d);
    return {^d, d};
  endfunction

  // drives beats first..last of d; beat 'bad' gets an extra off-lane bit
  task automatic drive(input logic [2:0] s, input logic [W:0] d, input int first, input int last, input int bad);
    for (int i = first; i <= last; i++) begin
      sel = s;
      Fi = d[i] ? (6'b1 << lane_of(s)) : 6'b0;
      if (i == bad) Fi = Fi | (6'b1 << (lane_of(s) == 3'd0 ? 2 : 0));
      fi_valid = 1'b1;
      @(posedge clk); #1;
    end
    fi_valid = 1'b0;
    Fi = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (res_word !== 8'h00) begin fails++; $display("FAIL reset_word got %h exp 00", res_word); end
    checks++; if (res_sel !== 3'b000) begin fails++; $display("FAIL reset_sel got %b exp 000", res_sel); end
    checks++; if (res_lane_err !== 1'b0) begin fails++; $display("FAIL reset_lane_err got %b exp 0", res_lane_err); end
    checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
    checks++; if (fi_ready !== 1'b1) begin fails++; $display("FAIL reset_fi_ready got %b exp 1", fi_ready); end
`ifdef ALU_RESULT_DESER_PARITY_EN
    checks++; if (res_par_err !== 1'b0) begin fails++; $display("FAIL reset_par_err got %b exp 0", res_par_err); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    res_ready = 1'b1;
    drive(3'b010, wd(8'hA5), 0, NB - 2, -1);
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", res_valid); end
    checks++; if (fi_ready !== 1'b1) begin fails++; $display("FAIL basic_early_ready got %b exp 1", fi_ready); end
    drive(3'b010, wd(8'hA5), NB - 1, NB - 1, -1);
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", res_valid); end
    checks++; if (res_word !== 8'hA5) begin fails++; $display("FAIL basic_word got %h exp a5", res_word); end
    checks++; if (res_sel !== 3'b010) begin fails++; $display("FAIL basic_sel got %b exp 010", res_sel); end
    checks++; if (res_lane_err !== 1'b0) begin fails++; $display("FAIL basic_lane_err got %b exp 0", res_lane_err); end
    checks++; if (fi_ready !== 1'b0) begin fails++; $display("FAIL basic_hold_ready got %b exp 0", fi_ready); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %b exp 0", res_valid); end
    checks++; if (fi_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back got %b exp 1", fi_ready); end
  endtask

  task automatic test_lane_err;
    drive(3'b000, wd(8'h0F), 0, NB - 1, 3);
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL lane_valid got %b exp 1", res_valid); end
    checks++; if (res_word !== 8'h0F) begin fails++; $display("FAIL lane_word got %h exp 0f", res_word); end
    checks++; if (res_lane_err !== 1'b1) begin fails++; $display("FAIL lane_err got %b exp 1", res_lane_err); end
    @(posedge clk); #1;
    drive(3'b000, wd(8'h33), 0, NB - 1, -1);
    checks++; if (res_word !== 8'h33) begin fails++; $display("FAIL lane_clean_word got %h exp 33", res_word); end
    checks++; if (res_lane_err !== 1'b0) begin fails++; $display("FAIL lane_clean_err got %b exp 0", res_lane_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_sel_err;
    drive(3'b110, wd(8'h0D), 0, 3, -1);
    checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL selerr_early got %b exp 0", sel_err); end
    drive(3'b111, wd(8'hFF), 4, 4, -1);
    checks++; if (sel_err !== 1'b1) begin fails++; $display("FAIL selerr_pulse got %b exp 1", sel_err); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL selerr_valid got %b exp 0", res_valid); end
    checks++; if (fi_ready !== 1'b1) begin fails++; $display("FAIL selerr_ready got %b exp 1", fi_ready); end
    @(posedge clk); #1;
    checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL selerr_width got %b exp 0", sel_err); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL selerr_valid2 got %b exp 0", res_valid); end
    drive(3'b111, wd(8'h3C), 0, NB - 1, -1);
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL selerr_next_valid got %b exp 1", res_valid); end
    checks++; if (res_word !== 8'h3C) begin fails++; $display("FAIL selerr_next_word got %h exp 3c", res_word); end
    checks++; if (res_sel !== 3'b111) begin fails++; $display("FAIL selerr_next_sel got %b exp 111", res_sel); end
    checks++; if (res_lane_err !== 1'b0) begin fails++; $display("FAIL selerr_next_lane got %b exp 0", res_lane_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    res_ready = 1'b0;
    drive(3'b011, wd(8'h5A), 0, NB - 1, -1);
    for (int c = 0; c < 5; c++) begin
      sel = 3'b011;
      Fi = 6'b001000;
      fi_valid = 1'b1;
      checks++; if (fi_ready !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d] got %b exp 0", c, fi_ready); end
      checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d] got %b exp 1", c, res_valid); end
      checks++; if (res_word !== 8'h5A) begin fails++; $display("FAIL hold_word[%0d] got %h exp 5a", c, res_word); end
      checks++; if (res_sel !== 3'b011) begin fails++; $display("FAIL hold_sel[%0d] got %b exp 011", c, res_sel); end
      checks++; if (res_lane_err !== 1'b0) begin fails++; $display("FAIL hold_lane[%0d] got %b exp 0", c, res_lane_err); end
      @(posedge clk); #1;
    end
    fi_valid = 1'b0;
    Fi = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL hold_release got %b exp 0", res_valid); end
    drive(3'b101, wd(8'hC3), 0, NB - 1, -1);
    checks++; if (res_word !== 8'hC3) begin fails++; $display("FAIL hold_next_word got %h exp c3", res_word); end
    checks++; if (res_sel !== 3'b101) begin fails++; $display("FAIL hold_next_sel got %b exp 101", res_sel); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    drive(3'b001, wd(8'hFF), 0, 2, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b exp 0", res_valid); end
    checks++; if (res_word !== 8'h00) begin fails++; $display("FAIL rmid_word got %h exp 00", res_word); end
    checks++; if (res_sel !== 3'b000) begin fails++; $display("FAIL rmid_sel got %b exp 000", res_sel); end
    checks++; if (fi_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b exp 1", fi_ready); end
    drive(3'b001, wd(8'h81), 0, NB - 1, -1);
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL rmid_next_valid got %b exp 1", res_valid); end
    checks++; if (res_word !== 8'h81) begin fails++; $display("FAIL rmid_next_word got %h exp 81", res_word); end
    checks++; if (res_lane_err !== 1'b0) begin fails++; $display("FAIL rmid_next_lane got %b exp 0", res_lane_err); end
    @(posedge clk); #1;
  endtask

`ifdef ALU_RESULT_DESER_PARITY_EN
  task automatic test_parity;
    drive(3'b010, {1'b0, 8'hA5}, 0, NB - 1, -1);
    checks++; if (res_word !== 8'hA5) begin fails++; $display("FAIL par_word got %h exp a5", res_word); end
    checks++; if (res_par_err !== 1'b0) begin fails++; $display("FAIL par_good got %b exp 0", res_par_err); end
    @(posedge clk); #1;
    drive(3'b010, {1'b1, 8'hA5}, 0, NB - 1, -1);
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL par_bad_valid got %b exp 1", res_valid); end
    checks++; if (res_par_err !== 1'b1) begin fails++; $display("FAIL par_bad got %b exp 1", res_par_err); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_lane_err();
    test_sel_err();
    test_hold();
    test_reset_mid();
`ifdef ALU_RESULT_DESER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
